// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI-mode responder: command indices,
// R1 status bits, token/fill bytes, FSM state encodings and CRC helpers.
package sd_spi_pkg;

    localparam logic [5:0] CMD_GO_IDLE     = 6'd0;
    localparam logic [5:0] CMD_SEND_OP     = 6'd1;
    localparam logic [5:0] CMD_SEND_IF     = 6'd8;
    localparam logic [5:0] CMD_READ_SINGLE = 6'd17;
    localparam logic [5:0] ACMD_SEND_OP    = 6'd41;
    localparam logic [5:0] CMD_APP_CMD     = 6'd55;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IN_IDLE = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] R1_CRC_ERR = 8'h08;

    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;
    localparam int         BLOCK_BYTES = 512;

    typedef enum logic [3:0] {
        S_WAIT,
        S_CMD,
        S_NCR,
        S_R1,
        S_R7,
        S_TOKDLY,
        S_TOKEN,
        S_DATA,
        S_CRC
    } state_t;

    typedef enum logic [1:0] {
        RESP_R1,
        RESP_R7,
        RESP_READ
    } resp_t;

    // CRC7 (x^7 + x^3 + 1) advanced by one byte, MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[6] ^ data[i];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction

    // CRC16-CCITT (poly 0x1021) advanced by one byte, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[15] ^ data[i];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ 16'h1021;
        end
        return crc;
    endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte shifter: synchronises sclk/ss/mosi into the clock domain,
// detects sclk edges, assembles received bytes and shifts tx bytes out on miso.
// A new tx byte is loaded on the falling edge that follows each 8th rising edge.
module sd_spi_shifter (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    input  logic [7:0] tx_byte,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       ss_idle,
    output logic       miso
);

    // bit order in the sync vectors: {sclk, ss, mosi}
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;

    logic sclk_s, ss_s, mosi_s;
    logic rise, fall;

    assign sclk_s = sync_q[2];
    assign ss_s   = sync_q[1];
    assign mosi_s = sync_q[0];

    // Next-state for synchroniser, edge detector, rx assembly and tx shift.
    always_comb begin
        meta_d      = {sclk, ss, mosi};
        sync_d      = meta_q;
        sclk_prev_d = sclk_s;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_valid_d  = 1'b0;
        rx_byte_d   = rx_byte_q;
        rise        = sclk_s & ~sclk_prev_q;
        fall        = ~sclk_s & sclk_prev_q;
        if (ss_s) begin
            bit_cnt_d = 3'd0;
            tx_sh_d   = 8'hFF;
        end else begin
            if (rise) begin
                rx_sh_d   = {rx_sh_q[6:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = {rx_sh_q[6:0], mosi_s};
                end
            end
            if (fall) begin
                if (bit_cnt_q == 3'd0) tx_sh_d = tx_byte;
                else                   tx_sh_d = {tx_sh_q[6:0], 1'b1};
            end
        end
    end

    // Register update; reset leaves ss deasserted so miso idles high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q      <= 3'b010;
            sync_q      <= 3'b010;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'h00;
            tx_sh_q     <= 8'hFF;
            rx_valid_q  <= 1'b0;
            rx_byte_q   <= 8'h00;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_valid_q  <= rx_valid_d;
            rx_byte_q   <= rx_byte_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;
    assign ss_idle  = ss_s;
    assign miso     = ss_s | tx_sh_q[7];

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: decodes 6-byte command frames and answers with
// R1 / R7 / single-block read responses. Block data is fetched one byte ahead
// through mem_addr/mem_rd/mem_data.
// Build option: SD_RESPONDER_CRC_EN enables command CRC7 checking and real
// CRC16 trailer bytes; otherwise CRC is ignored and the trailer is 0xFFFF.
//
// state    | meaning
// S_WAIT   | idle, looking for a 01xxxxxx command byte
// S_CMD    | collecting 4 argument bytes and the CRC byte
// S_NCR    | sending 0xFF fill before R1
// S_R1     | sending R1
// S_R7     | sending the 4 trailing CMD8 bytes
// S_TOKDLY | sending 0xFF fill before the data token
// S_TOKEN  | sending the 0xFE start token
// S_DATA   | sending 512 block bytes
// S_CRC    | sending the 2 block CRC bytes
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int RESP_DELAY  = 1,
    parameter int TOKEN_DELAY = 2,
    parameter int INIT_POLLS  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        card_ready
);

`ifdef SD_RESPONDER_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       ss_idle;

    state_t      state_q, state_d;
    resp_t       resp_q, resp_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  r1_q, r1_d;
    logic        in_idle_q, in_idle_d;
    logic [15:0] poll_q, poll_d;
    logic        app_q, app_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  buf_q, buf_d;
    logic [6:0]  crc7_q, crc7_d;
    logic [15:0] crc16_q, crc16_d;

    logic        crc_ok;
    logic [7:0]  ex_r1;
    resp_t       ex_resp;
    logic        ex_in_idle;
    logic [15:0] ex_poll;
    logic        ex_app;
    logic [7:0]  crc_hi, crc_lo;

    sd_spi_shifter u_shifter (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .ss       (ss),
        .mosi     (mosi),
        .tx_byte  (tx_q),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .ss_idle  (ss_idle),
        .miso     (miso)
    );

    // Command decode: effect of executing the collected frame on card state.
    always_comb begin
        crc_ok     = !CRC_EN || (rx_byte[7:1] == crc7_q);
        ex_in_idle = in_idle_q;
        ex_poll    = poll_q;
        ex_app     = 1'b0;
        ex_resp    = RESP_R1;
        ex_r1      = R1_ILLEGAL | {7'b0, in_idle_q};
        crc_hi     = CRC_EN ? crc16_q[15:8] : FILL_BYTE;
        crc_lo     = CRC_EN ? crc16_q[7:0]  : FILL_BYTE;
        if (!crc_ok) begin
            ex_r1  = R1_CRC_ERR | {7'b0, in_idle_q};
            ex_app = app_q;
        end else begin
            case (cmd_q)
                CMD_GO_IDLE: begin
                    ex_in_idle = 1'b1;
                    ex_poll    = 16'd0;
                    ex_r1      = R1_IN_IDLE;
                end
                CMD_SEND_IF: begin
                    ex_r1   = {7'b0, in_idle_q};
                    ex_resp = RESP_R7;
                end
                CMD_APP_CMD: begin
                    ex_r1  = {7'b0, in_idle_q};
                    ex_app = 1'b1;
                end
                CMD_SEND_OP, ACMD_SEND_OP: begin
                    if (cmd_q == CMD_SEND_OP || app_q) begin
                        if (poll_q < 16'(INIT_POLLS)) begin
                            ex_r1   = R1_IN_IDLE;
                            ex_poll = poll_q + 16'd1;
                        end else begin
                            ex_r1      = R1_READY;
                            ex_in_idle = 1'b0;
                        end
                    end
                end
                CMD_READ_SINGLE: begin
                    if (!in_idle_q) begin
                        ex_r1   = R1_READY;
                        ex_resp = RESP_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-level FSM: on each completed SPI byte choose the next byte to shift out.
    // Block bytes are prefetched one byte ahead so mem_rd leads its bit time by a full byte.
    always_comb begin
        state_d    = state_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        tx_d       = tx_q;
        r1_d       = r1_q;
        in_idle_d  = in_idle_q;
        poll_d     = poll_q;
        app_d      = app_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        rd_pend_d  = mem_rd_q;
        buf_d      = rd_pend_q ? mem_data : buf_q;
        crc7_d     = crc7_q;
        crc16_d    = crc16_q;
        if (ss_idle) begin
            state_d = S_WAIT;
            tx_d    = FILL_BYTE;
        end else if (rx_valid) begin
            tx_d = FILL_BYTE;
            case (state_q)
                S_WAIT: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        state_d = S_CMD;
                        cmd_d   = rx_byte[5:0];
                        cnt_d   = 16'd4;
                        crc7_d  = crc7_byte(7'd0, rx_byte);
                    end
                end
                S_CMD: begin
                    if (cnt_q != 16'd0) begin
                        arg_d  = {arg_q[23:0], rx_byte};
                        cnt_d  = cnt_q - 16'd1;
                        crc7_d = crc7_byte(crc7_q, rx_byte);
                    end else begin
                        in_idle_d = ex_in_idle;
                        poll_d    = ex_poll;
                        app_d     = ex_app;
                        resp_d    = ex_resp;
                        r1_d      = ex_r1;
                        if (ex_resp == RESP_READ) begin
                            mem_addr_d = arg_q;
                            mem_rd_d   = 1'b1;
                            crc16_d    = 16'd0;
                        end
                        if (RESP_DELAY == 0) begin
                            state_d = S_R1;
                            tx_d    = ex_r1;
                        end else begin
                            state_d = S_NCR;
                            cnt_d   = 16'(RESP_DELAY - 1);
                        end
                    end
                end
                S_NCR: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_R1;
                        tx_d    = r1_q;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_R1: begin
                    case (resp_q)
                        RESP_R7: begin
                            state_d = S_R7;
                            tx_d    = 8'h00;
                            cnt_d   = 16'd3;
                        end
                        RESP_READ: begin
                            if (TOKEN_DELAY == 0) begin
                                state_d = S_TOKEN;
                                tx_d    = DATA_TOKEN;
                            end else begin
                                state_d = S_TOKDLY;
                                cnt_d   = 16'(TOKEN_DELAY - 1);
                            end
                        end
                        default: state_d = S_WAIT;
                    endcase
                end
                S_R7: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        case (cnt_q[1:0])
                            2'd3:    tx_d = 8'h00;
                            2'd2:    tx_d = {4'h0, arg_q[11:8]};
                            default: tx_d = arg_q[7:0];
                        endcase
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_TOKDLY: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_TOKEN;
                        tx_d    = DATA_TOKEN;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_TOKEN: begin
                    state_d    = S_DATA;
                    tx_d       = buf_q;
                    crc16_d    = crc16_byte(crc16_q, buf_q);
                    cnt_d      = 16'(BLOCK_BYTES - 1);
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + 32'd1;
                end
                S_DATA: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_CRC;
                        tx_d    = crc_hi;
                        cnt_d   = 16'd1;
                    end else begin
                        tx_d    = buf_q;
                        crc16_d = crc16_byte(crc16_q, buf_q);
                        cnt_d   = cnt_q - 16'd1;
                        // cnt counts bytes still to send after this one; the last needs no fetch
                        if (cnt_q >= 16'd2) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = mem_addr_q + 32'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (cnt_q != 16'd0) begin
                        tx_d  = crc_lo;
                        cnt_d = 16'd0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    // State and card-status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT;
            resp_q     <= RESP_R1;
            cnt_q      <= 16'd0;
            cmd_q      <= 6'd0;
            arg_q      <= 32'd0;
            tx_q       <= FILL_BYTE;
            r1_q       <= FILL_BYTE;
            in_idle_q  <= 1'b1;
            poll_q     <= 16'd0;
            app_q      <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_rd_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            buf_q      <= 8'h00;
            crc7_q     <= 7'd0;
            crc16_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            tx_q       <= tx_d;
            r1_q       <= r1_d;
            in_idle_q  <= in_idle_d;
            poll_q     <= poll_d;
            app_q      <= app_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            rd_pend_q  <= rd_pend_d;
            buf_q      <= buf_d;
            crc7_q     <= crc7_d;
            crc16_q    <= crc16_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign card_ready = ~in_idle_q;

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter RESP_DELAY, default 1, meaning 0xFF fill bytes (Ncr) sent before every R1.
REQ-002 SHALL have parameter TOKEN_DELAY, default 2, meaning 0xFF fill bytes between R1 and data token for CMD17.
REQ-003 SHALL have parameter INIT_POLLS, default 2, meaning ACMD41/CMD1 commands answered 0x01 before card becomes ready.
REQ-004 clock  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sclk  input  1  SPI clock from host, asynchronous to clock.
REQ-007 ss  input  1  chip select, active low.
REQ-008 mosi  input  1  host-to-card data.
REQ-009 miso  output  1  card-to-host data.
REQ-010 mem_addr  output  32  byte address of requested block data.
REQ-011 mem_rd  output  1  one-cycle read strobe; mem_data valid the following clock.
REQ-012 mem_data  input  8  read data.
REQ-013 card_ready  output  1  high once initialisation has completed (in_idle cleared).

Function
REQ-014 SHALL synchronise sclk, ss, mosi through two flops; SPI mode 0: sample mosi on sclk rising edge, update miso on falling edge; sclk half-period >= 4 clocks.
REQ-015 ss high SHALL force miso=1, clear bit counter, and return FSM to S_WAIT within 3 clocks; card state (in_idle, poll count) preserved.
REQ-016 S_WAIT: received byte with bits[7:6]=01 starts a frame -> S_CMD; other bytes ignored, miso=1.
REQ-017 S_CMD: collect 5 more bytes (32-bit argument MSB first, CRC byte) -> S_NCR; command executes on 6th byte.
REQ-018 S_NCR: shift RESP_DELAY bytes of 0xFF -> S_R1; S_R1 shifts R1 byte, bit0 = in_idle.
REQ-019 CMD0 -> R1 0x01, in_idle=1, poll count=0, app flag cleared.
REQ-020 CMD8 -> R1 0x01|... followed by S_R7 shifting 0x00,0x00, 0x0 concatenated with arg[11:8], arg[7:0].
REQ-021 CMD55 -> R1 {0x00|in_idle}, set app flag; flag cleared by any following command.
REQ-022 ACMD41 or CMD1 -> R1 0x01 while poll count < INIT_POLLS (count increments), else R1 0x00 and in_idle=0.
REQ-023 CMD17 with in_idle=0 -> R1 0x00, TOKEN_DELAY 0xFF bytes, token 0xFE, 512 data bytes from mem_addr=arg..arg+511, 2 CRC bytes, then S_WAIT.
REQ-024 CMD17 with in_idle=1, or any other index -> R1 0x04|in_idle, no data phase.
REQ-025 mem_rd SHALL pulse once per data byte at least 8 clocks before its first bit is due; mem_addr increments by 1 per byte, 32-bit wrap.
REQ-026 bytes received on mosi during response/data phases SHALL be ignored (no new command until S_WAIT).
REQ-027 card_ready = ~in_idle.

Reset
REQ-028 reset SHALL set: FSM S_WAIT, miso=1, mem_rd=0, mem_addr=0, in_idle=1, card_ready=0, poll count=0, app flag=0.

Configuration
REQ-029 Macro SD_RESPONDER_CRC_EN: defined -> CRC7 of first 5 command bytes checked; mismatch -> R1 0x08|in_idle, command not executed; data CRC bytes = CRC16-CCITT (poly 0x1021, init 0) of 512 data bytes.
REQ-030 Macro undefined -> CRC byte ignored, data CRC bytes 0xFF,0xFF.

Structure
REQ-031 Package sd_spi_pkg SHALL hold command indices (0,1,8,17,41,55), R1 bit constants, token 0xFE, FSM state enum.
REQ-032 Sub-module sd_spi_shifter SHALL implement sync, edge detect, byte receive/transmit; instantiated once.

Verification
REQ-033 CMD0 (40 00 00 00 00 95) -> after 1 0xFF, R1 0x01; card_ready=0.
REQ-034 CMD8 arg 0x000001AA -> R1 0x01 then 00 00 01 AA.
REQ-035 CMD55+ACMD41 x3 -> R1 0x01, 0x01, 0x00; card_ready rises after third.
REQ-036 CMD17 arg 0x200 after ready, mem_data=addr[7:0] -> FF FF FE, bytes 00..FF twice, mem_addr ends 0x3FF, CRC 0xFFFF (or computed with macro).
REQ-037 ss high at data byte 100 -> miso=1 within 3 clocks; next CMD17 served fully, card_ready stays 1.
REQ-038 CMD17 before init, and CMD9 -> R1 0x05; with macro, CMD0 CRC 0x00 -> R1 0x09.
